host_channel_owner_ctrl: RTL

- Sequences ownership of the shared host item channel between the host request manager (boot/command sessions) and the debug support unit (DSU sessions).
- Generates the mutually exclusive `wait_boot` / `wait_dsu` selects consumed by the host-side channel mux.
- Arbitrates simultaneous session requests round-robin.
- Guarantees a quiet drain interval before ownership changes hands, so no item is split across owners.

---
 rtl/host_channel_owner_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/host_channel_owner_ctrl.sv
// host_channel_owner_ctrl
// Arbitrates ownership of the shared host item channel between the host
// request manager (boot/command sessions) and the debug support unit (DSU).
// Contention is resolved round-robin. A quiet drain interval separates
// sessions so that no item is split across two owners.
// Optional watchdog release of a silent session: define HOST_CHANNEL_WATCHDOG_EN.

module host_channel_owner_ctrl #(
    parameter int unsigned DRAIN_CYCLES    = 4,
    parameter int unsigned CNT_w           = 8,
    parameter int unsigned WATCHDOG_CYCLES = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot_req_i,
    input  logic       boot_done_i,
    input  logic       dsu_req_i,
    input  logic       dsu_done_i,
    input  logic       item_valid_i,
    input  logic       item_valid_o,
    output logic       wait_boot,
    output logic       wait_dsu,
    output logic [1:0] owner_o,
    output logic       timeout_o
);

    // The encoding doubles as the owner_o value.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BOOT  = 2'd1,
        ST_DSU   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // A zero-length drain skips the DRAIN state entirely.
    localparam logic             DRAIN_EN   = (DRAIN_CYCLES != 32'd0);
    localparam logic [CNT_w-1:0] DRAIN_LOAD = DRAIN_EN ? CNT_w'(DRAIN_CYCLES - 32'd1)
                                                       : {CNT_w{1'b0}};
    localparam logic [CNT_w-1:0] CNT_ZERO   = {CNT_w{1'b0}};
    localparam logic [CNT_w-1:0] CNT_ONE    = {{(CNT_w-1){1'b0}}, 1'b1};
    localparam state_e           END_STATE  = DRAIN_EN ? ST_DRAIN : ST_IDLE;

    // Both counters must be able to hold their terminal values.
    if ((DRAIN_CYCLES >= (32'd1 << CNT_w)) || (WATCHDOG_CYCLES >= (32'd1 << CNT_w))) begin : g_param_check
        $error("host_channel_owner_ctrl: DRAIN_CYCLES/WATCHDOG_CYCLES exceed CNT_w range");
    end

    state_e           state_q, state_d;
    logic             last_dsu_q, last_dsu_d;      // 1: DSU held the channel last
    logic [CNT_w-1:0] drain_cnt_q, drain_cnt_d;
    logic             wait_boot_q, wait_boot_d;
    logic             wait_dsu_q, wait_dsu_d;
    logic [1:0]       owner_q, owner_d;
    logic             traffic_s;
    logic             done_s;
    logic             session_end_s;

`ifdef HOST_CHANNEL_WATCHDOG_EN
    localparam logic [CNT_w-1:0] WD_LAST = CNT_w'(WATCHDOG_CYCLES - 32'd1);
    localparam logic [CNT_w-1:0] WD_MAX  = {CNT_w{1'b1}};
    logic [CNT_w-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    assign traffic_s = item_valid_i | item_valid_o;

    // Next-state, grant arbitration and drain/watchdog counter computation.
    always_comb begin
        state_d       = state_q;
        last_dsu_d    = last_dsu_q;
        drain_cnt_d   = drain_cnt_q;
        done_s        = 1'b0;
        session_end_s = 1'b0;
`ifdef HOST_CHANNEL_WATCHDOG_EN
        timeout_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                drain_cnt_d = CNT_ZERO;
                // On a tie, the requester that did not own the channel last wins.
                if (boot_req_i && (!dsu_req_i || last_dsu_q)) begin
                    state_d    = ST_BOOT;
                    last_dsu_d = 1'b0;
                end else if (dsu_req_i) begin
                    state_d    = ST_DSU;
                    last_dsu_d = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_BOOT, ST_DSU: begin
                // Only the owner's own done pulse ends the session; the other side is ignored.
                if (state_q == ST_BOOT) begin
                    done_s = boot_done_i;
                end else begin
                    done_s = dsu_done_i;
                end
                if (done_s) begin
                    session_end_s = 1'b1;
`ifdef HOST_CHANNEL_WATCHDOG_EN
                end else if (!traffic_s && (wd_cnt_q == WD_LAST)) begin
                    session_end_s = 1'b1;
                    timeout_d     = 1'b1;
`endif
                end else begin
                    session_end_s = 1'b0;
                end
                if (session_end_s) begin
                    state_d     = END_STATE;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    state_d     = state_q;
                end
            end
            ST_DRAIN: begin
                // Any traffic restarts the quiet interval; the counter never wraps below zero.
                if (traffic_s) begin
                    drain_cnt_d = DRAIN_LOAD;
                end else if (drain_cnt_q == CNT_ZERO) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = CNT_ZERO;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                drain_cnt_d = CNT_ZERO;
            end
        endcase

`ifdef HOST_CHANNEL_WATCHDOG_EN
        // Counts consecutive quiet cycles of a live session; zero outside sessions.
        if (((state_q == ST_BOOT) || (state_q == ST_DSU)) && !session_end_s && !traffic_s) begin
            if (wd_cnt_q == WD_MAX) begin
                wd_cnt_d = wd_cnt_q;
            end else begin
                wd_cnt_d = wd_cnt_q + CNT_ONE;
            end
        end else begin
            wd_cnt_d = CNT_ZERO;
        end
`endif

        wait_boot_d = (state_d == ST_BOOT);
        wait_dsu_d  = (state_d == ST_DSU);
        owner_d     = state_d;
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_dsu_q  <= 1'b1;
            drain_cnt_q <= CNT_ZERO;
            wait_boot_q <= 1'b0;
            wait_dsu_q  <= 1'b0;
            owner_q     <= 2'd0;
`ifdef HOST_CHANNEL_WATCHDOG_EN
            wd_cnt_q    <= CNT_ZERO;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_dsu_q  <= last_dsu_d;
            drain_cnt_q <= drain_cnt_d;
            wait_boot_q <= wait_boot_d;
            wait_dsu_q  <= wait_dsu_d;
            owner_q     <= owner_d;
`ifdef HOST_CHANNEL_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign wait_boot = wait_boot_q;
    assign wait_dsu  = wait_dsu_q;
    assign owner_o   = owner_q;
`ifdef HOST_CHANNEL_WATCHDOG_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

`ifdef SIMULATION
    // The channel mux must never see both selects at once.
    a_selects_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(wait_boot_q && wait_dsu_q));
`endif

endmodule
